tlp2dllp: RTL and testbench



---
 rtl/tlp2dllp.sv | 264 ++++++++++++++++++++++++++
 tb/tb_tlp2dllp.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp2dllp.sv
`timescale 1ns/1ps
// tlp2dllp: wraps each TLP into a DLLP (sequence header, pass-through data, LCRC),
// logs every transmitted beat into an external retry RAM and replays it on request.
module tlp2dllp #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned KEEP_WIDTH     = 4,
    parameter int unsigned USER_WIDTH     = 3,
    parameter int unsigned S_COUNT        = 1,
    parameter int unsigned RAM_DATA_WIDTH = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata_i,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep_i,
    input  logic [S_COUNT-1:0]        s_axis_tvalid_i,
    input  logic [S_COUNT-1:0]        s_axis_tlast_i,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser_i,
    output logic [S_COUNT-1:0]        s_axis_tready_o,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep_o,
    output logic                      m_axis_tvalid_o,
    output logic                      m_axis_tlast_o,
    output logic [USER_WIDTH-1:0]     m_axis_tuser_o,
    input  logic                      m_axis_tready_i,
    output logic                      bram_wr_o,
    output logic [RAM_ADDR_WIDTH-1:0] bram_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] bram_data_out_o,
    input  logic [RAM_DATA_WIDTH-1:0] bram_data_in_i,
    output logic [15:0]               seq_num_o,
    output logic                      dllp_valid_o,
    input  logic                      retry_available_i,
    input  logic [7:0]                retry_index_i,
    input  logic [7:0]                tx_fc_ph_i,
    input  logic [11:0]               tx_fc_pd_i,
    input  logic [7:0]                tx_fc_nph_i,
    input  logic [11:0]               tx_fc_npd_i
);

    localparam int unsigned SEQ_W = 12;
    localparam int unsigned IDX_W = RAM_ADDR_WIDTH + 1;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR       = 3'd1,
        DATA      = 3'd2,
        LCRC      = 3'd3,
        REPLAY_RD = 3'd4,
        REPLAY    = 3'd5
    } state_t;

    state_t                    state_q;
    state_t                    state_d;

    logic [SEQ_W-1:0]          seq_q;
    logic [31:0]               crc_q;
    logic [IDX_W-1:0]          idx_q;
    logic [USER_WIDTH-1:0]     tuser_q;
    logic [RAM_ADDR_WIDTH-1:0] rp_idx_q;
    logic [RAM_ADDR_WIDTH-1:0] rp_last_q;

    logic                      credit_ok;
    logic                      start;
    logic                      data_fire;
    logic                      wr_ok;
    logic [IDX_W-1:0]          idx_inc;
    logic [15:0]               hdr_word;
    logic [31:0]               crc_hdr;
    logic [31:0]               crc_dat;
    logic                      rp_at_last;
    logic                      unused_inputs;

    // Reflected CRC-32 update for one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    assign unused_inputs = ^{s_axis_tkeep_i, retry_index_i[7:RAM_ADDR_WIDTH]};

    assign hdr_word   = {seq_q[7:0], 4'h0, seq_q[11:8]};
    assign data_fire  = s_axis_tvalid_i[0] & m_axis_tready_i;
    assign wr_ok      = ~idx_q[IDX_W-1];
    assign idx_inc    = wr_ok ? (idx_q + IDX_W'(1)) : idx_q;
    assign rp_at_last = (rp_idx_q == rp_last_q);
    assign start      = s_axis_tvalid_i[0] & credit_ok;
    assign seq_num_o  = {4'b0, seq_q};

    // Flow-control gate for a new TLP, keyed on its type in tuser[1:0].
    always_comb begin
        credit_ok = 1'b1;
        case (s_axis_tuser_i[1:0])
            2'b00:   credit_ok = (tx_fc_ph_i != '0) && (tx_fc_pd_i != '0);
            2'b01:   credit_ok = (tx_fc_nph_i != '0) && (tx_fc_npd_i != '0);
            default: credit_ok = 1'b1;
        endcase
    end

    // Running LCRC after the header bytes and after one data DW (byte0 first).
    always_comb begin
        crc_hdr = crc_byte(crc_byte(crc_q, hdr_word[7:0]), hdr_word[15:8]);
        crc_dat = crc_q;
        for (int b = 0; b < 4; b++) begin
            crc_dat = crc_byte(crc_dat, s_axis_tdata_i[b*8 +: 8]);
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; replay requests win over new TLPs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (retry_available_i) begin
                    state_d = REPLAY_RD;
                end else if (start) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (m_axis_tready_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (data_fire && s_axis_tlast_i[0]) begin
                    state_d = LCRC;
                end
            end
            LCRC: begin
                if (m_axis_tready_i) begin
                    state_d = IDLE;
                end
            end
            REPLAY_RD: begin
                state_d = REPLAY;
            end
            REPLAY: begin
                if (m_axis_tready_i && rp_at_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; replay pre-addresses word k+1 as word k leaves.
    always_comb begin
        s_axis_tready_o = '0;
        m_axis_tdata_o  = '0;
        m_axis_tkeep_o  = '0;
        m_axis_tvalid_o = 1'b0;
        m_axis_tlast_o  = 1'b0;
        m_axis_tuser_o  = tuser_q;
        bram_wr_o       = 1'b0;
        bram_addr_o     = '0;
        dllp_valid_o    = 1'b0;
        case (state_q)
            HDR: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = DATA_WIDTH'(hdr_word);
                m_axis_tkeep_o  = KEEP_WIDTH'(4'b0011);
                bram_wr_o       = m_axis_tready_i & wr_ok;
                bram_addr_o     = idx_q[RAM_ADDR_WIDTH-1:0];
            end
            DATA: begin
                s_axis_tready_o[0] = m_axis_tready_i;
                m_axis_tvalid_o    = s_axis_tvalid_i[0];
                m_axis_tdata_o     = s_axis_tdata_i;
                m_axis_tkeep_o     = '1;
                bram_wr_o          = data_fire & wr_ok;
                bram_addr_o        = idx_q[RAM_ADDR_WIDTH-1:0];
            end
            LCRC: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = DATA_WIDTH'(~crc_q);
                m_axis_tkeep_o  = '1;
                m_axis_tlast_o  = 1'b1;
                bram_wr_o       = m_axis_tready_i & wr_ok;
                bram_addr_o     = idx_q[RAM_ADDR_WIDTH-1:0];
                dllp_valid_o    = m_axis_tready_i;
            end
            REPLAY_RD: begin
                bram_addr_o = '0;
            end
            REPLAY: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = DATA_WIDTH'(bram_data_in_i);
                m_axis_tkeep_o  = (rp_idx_q == '0) ? KEEP_WIDTH'(4'b0011) : '1;
                m_axis_tlast_o  = rp_at_last;
                bram_addr_o     = m_axis_tready_i ? (rp_idx_q + RAM_ADDR_WIDTH'(1)) : rp_idx_q;
            end
            default: begin
                m_axis_tvalid_o = 1'b0;
            end
        endcase
        bram_data_out_o = RAM_DATA_WIDTH'(m_axis_tdata_o);
    end

    // Datapath: sequence number, running CRC, beat index, captured tuser, replay pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq_q     <= '0;
            crc_q     <= '0;
            idx_q     <= '0;
            tuser_q   <= '0;
            rp_idx_q  <= '0;
            rp_last_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (retry_available_i) begin
                        rp_idx_q  <= '0;
                        rp_last_q <= retry_index_i[RAM_ADDR_WIDTH-1:0];
                    end else if (start) begin
                        tuser_q <= s_axis_tuser_i;
                        crc_q   <= '1;
                        idx_q   <= '0;
                    end
                end
                HDR: begin
                    if (m_axis_tready_i) begin
                        crc_q <= crc_hdr;
                        idx_q <= idx_inc;
                    end
                end
                DATA: begin
                    if (data_fire) begin
                        crc_q <= crc_dat;
                        idx_q <= idx_inc;
                    end
                end
                LCRC: begin
                    if (m_axis_tready_i) begin
                        seq_q <= seq_q + SEQ_W'(1);
                        idx_q <= idx_inc;
                    end
                end
                REPLAY: begin
                    if (m_axis_tready_i) begin
                        rp_idx_q <= rp_idx_q + RAM_ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    rp_idx_q <= rp_idx_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlp2dllp.sv
`timescale 1ns/1ps
// Directed bench for tlp2dllp: framing, LCRC, credits, backpressure, seq wrap, replay.
module tb_tlp2dllp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic [2:0]  s_tuser;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic [2:0]  m_tuser;
    logic        m_tready;
    logic        bram_wr;
    logic [4:0]  bram_addr;
    logic [31:0] bram_dout;
    logic [31:0] bram_din;
    logic [15:0] seq_num;
    logic        dllp_valid;
    logic        retry;
    logic [7:0]  retry_index;
    logic [7:0]  fc_ph;
    logic [11:0] fc_pd;
    logic [7:0]  fc_nph;
    logic [11:0] fc_npd;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    logic [31:0] ram [0:31];
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;

    always #5 clk = ~clk;

    tlp2dllp dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .s_axis_tdata_i    (s_tdata),
        .s_axis_tkeep_i    (s_tkeep),
        .s_axis_tvalid_i   (s_tvalid),
        .s_axis_tlast_i    (s_tlast),
        .s_axis_tuser_i    (s_tuser),
        .s_axis_tready_o   (s_tready),
        .m_axis_tdata_o    (m_tdata),
        .m_axis_tkeep_o    (m_tkeep),
        .m_axis_tvalid_o   (m_tvalid),
        .m_axis_tlast_o    (m_tlast),
        .m_axis_tuser_o    (m_tuser),
        .m_axis_tready_i   (m_tready),
        .bram_wr_o         (bram_wr),
        .bram_addr_o       (bram_addr),
        .bram_data_out_o   (bram_dout),
        .bram_data_in_i    (bram_din),
        .seq_num_o         (seq_num),
        .dllp_valid_o      (dllp_valid),
        .retry_available_i (retry),
        .retry_index_i     (retry_index),
        .tx_fc_ph_i        (fc_ph),
        .tx_fc_pd_i        (fc_pd),
        .tx_fc_nph_i       (fc_nph),
        .tx_fc_npd_i       (fc_npd)
    );

    // Retry RAM with one-cycle registered read; bench preload port takes priority.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (bram_wr) begin
            ram[bram_addr] <= bram_dout;
        end
        bram_din <= ram[bram_addr];
    end

    // Count dllp_valid pulses away from the active edge.
    always @(negedge clk) begin
        if (dllp_valid) pulses++;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference CRC-32 (reflected): feed one byte LSB first.
    function automatic logic [31:0] ref_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    function automatic logic [31:0] ref_dw(input logic [31:0] c_in, input logic [31:0] dw);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 4; i++) c = ref_byte(c, dw[i*8 +: 8]);
        return c;
    endfunction

    function automatic logic [31:0] ref_hdr(input logic [11:0] seq);
        logic [31:0] c;
        c = ref_byte(32'hFFFFFFFF, {4'h0, seq[11:8]});
        c = ref_byte(c, seq[7:0]);
        return c;
    endfunction

    // One-DW completion at full throughput, no checks.
    task automatic send_short(input logic [31:0] dw);
        s_tuser  = 3'b010;
        s_tdata  = dw;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        step();
        step();
        step();
        s_tvalid = 1'b0;
        step();
    endtask

    logic [31:0] exp_crc;
    logic [11:0] exp_seq;
    int          pulses_snap;
    logic [31:0] rdat [0:4];

    initial begin
        rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
        m_tready = 1'b1; retry = 1'b0; retry_index = '0;
        fc_ph = '0; fc_pd = '0; fc_nph = '0; fc_npd = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        rdat[0] = 32'h0000_0A0B; rdat[1] = 32'h1111_2222; rdat[2] = 32'h3333_4444;
        rdat[3] = 32'h5555_6666; rdat[4] = 32'h7777_8888;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chkb("rst_tready", s_tready, 1'b0);
        chkb("rst_tvalid", m_tvalid, 1'b0);
        chkb("rst_bram_wr", bram_wr, 1'b0);
        chkb("rst_dllp_valid", dllp_valid, 1'b0);
        chk("rst_seq", 32'(seq_num), 32'h0);
        step();

        // Completion TLP of 3 DWs, tready held high
        s_tuser = 3'b110; s_tvalid = 1'b1; s_tdata = 32'h11223344; s_tlast = 1'b0;
        #1;
        chkb("t1_idle_tready", s_tready, 1'b0);
        chkb("t1_idle_tvalid", m_tvalid, 1'b0);
        step();
        #1;
        chk("t1_hdr_data", m_tdata, 32'h0000_0000);
        chk("t1_hdr_keep", 32'(m_tkeep), 32'h3);
        chkb("t1_hdr_last", m_tlast, 1'b0);
        chk("t1_hdr_user", 32'(m_tuser), 32'h6);
        chkb("t1_hdr_tready", s_tready, 1'b0);
        chkb("t1_hdr_wr", bram_wr, 1'b1);
        chk("t1_hdr_addr", 32'(bram_addr), 32'd0);
        step();
        #1;
        chk("t1_d0_data", m_tdata, 32'h11223344);
        chkb("t1_d0_tready", s_tready, 1'b1);
        chk("t1_d0_keep", 32'(m_tkeep), 32'hF);
        chk("t1_d0_addr", 32'(bram_addr), 32'd1);
        step();
        s_tdata = 32'h55667788;
        #1;
        chk("t1_d1_addr", 32'(bram_addr), 32'd2);
        step();
        s_tdata = 32'h99aabbcc; s_tlast = 1'b1;
        #1;
        chk("t1_d2_data", m_tdata, 32'h99aabbcc);
        chkb("t1_d2_last", m_tlast, 1'b0);
        chk("t1_d2_addr", 32'(bram_addr), 32'd3);
        step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        exp_crc = ~ref_dw(ref_dw(ref_dw(ref_hdr(12'd0), 32'h11223344), 32'h55667788), 32'h99aabbcc);
        #1;
        chk("t1_lcrc_data", m_tdata, exp_crc);
        chkb("t1_lcrc_last", m_tlast, 1'b1);
        chk("t1_lcrc_keep", 32'(m_tkeep), 32'hF);
        chkb("t1_lcrc_dllp_valid", dllp_valid, 1'b1);
        chk("t1_lcrc_addr", 32'(bram_addr), 32'd4);
        chkb("t1_lcrc_tready", s_tready, 1'b0);
        step();
        #1;
        chk("t1_seq", 32'(seq_num), 32'd1);
        chkb("t1_dllp_valid_off", dllp_valid, 1'b0);
        chkb("t1_idle_tvalid2", m_tvalid, 1'b0);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_ram0", ram[0], 32'h0);
        chk("t1_ram3", ram[3], 32'h99aabbcc);
        chk("t1_ram4", ram[4], exp_crc);

        // Reset in the middle of a DLLP aborts it
        s_tuser = 3'b010; s_tvalid = 1'b1; s_tdata = 32'hdeadbeef; s_tlast = 1'b0;
        step();
        step();
        #1;
        chkb("t2_in_data", s_tready, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0; s_tvalid = 1'b0;
        #1;
        chkb("t2_abort_tvalid", m_tvalid, 1'b0);
        chkb("t2_abort_tready", s_tready, 1'b0);
        chk("t2_abort_seq", 32'(seq_num), 32'd0);
        step();
        chk("t2_abort_pulses", 32'(pulses), 32'd1);

        // LCRC against reference for seq 0 and bytes "1234567" (DW padded with 00)
        s_tuser = 3'b010; s_tvalid = 1'b1; s_tdata = 32'h34333231; s_tlast = 1'b0;
        step();
        #1;
        chk("t3_hdr_data", m_tdata, 32'h0000_0000);
        step();
        step();
        s_tdata = 32'h00373635; s_tlast = 1'b1;
        step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        exp_crc = ~ref_dw(ref_dw(ref_hdr(12'd0), 32'h34333231), 32'h00373635);
        #1;
        chk("t3_lcrc_data", m_tdata, exp_crc);
        step();
        #1;
        chk("t3_seq", 32'(seq_num), 32'd1);

        // Posted TLP blocked by zero header credits
        s_tuser = 3'b000; s_tvalid = 1'b1; s_tdata = 32'hcafef00d; s_tlast = 1'b1;
        fc_ph = 8'd0; fc_pd = 12'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chkb("t4_blocked_tready", s_tready, 1'b0);
            chkb("t4_blocked_tvalid", m_tvalid, 1'b0);
            step();
        end
        fc_ph = 8'd1; fc_pd = 12'd1;
        step();
        #1;
        chk("t4_hdr_data", m_tdata, 32'h0000_0100);
        step();
        m_tready = 1'b0;
        #1;
        chkb("t4_stall_tready", s_tready, 1'b0);
        chkb("t4_stall_tvalid", m_tvalid, 1'b1);
        chk("t4_stall_data", m_tdata, 32'hcafef00d);
        chkb("t4_stall_wr", bram_wr, 1'b0);
        step();
        m_tready = 1'b1;
        #1;
        chkb("t4_go_wr", bram_wr, 1'b1);
        chk("t4_go_addr", 32'(bram_addr), 32'd1);
        step();
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        exp_crc = ~ref_dw(ref_hdr(12'd1), 32'hcafef00d);
        #1;
        chk("t4_lcrc_stall_data", m_tdata, exp_crc);
        chkb("t4_lcrc_stall_last", m_tlast, 1'b1);
        chkb("t4_lcrc_stall_dllp", dllp_valid, 1'b0);
        chkb("t4_lcrc_stall_wr", bram_wr, 1'b0);
        step();
        #1;
        chk("t4_lcrc_hold_data", m_tdata, exp_crc);
        m_tready = 1'b1;
        #1;
        chkb("t4_lcrc_dllp", dllp_valid, 1'b1);
        step();
        #1;
        chk("t4_seq", 32'(seq_num), 32'd2);
        chk("t4_pulses", 32'(pulses), 32'd3);

        // Non-posted TLP blocked by zero data credits
        s_tuser = 3'b001; s_tvalid = 1'b1; fc_nph = 8'd1; fc_npd = 12'd0;
        step();
        #1;
        chkb("t4_np_blocked", m_tvalid, 1'b0);
        s_tvalid = 1'b0; fc_ph = '0; fc_pd = '0; fc_nph = '0;
        step();

        // Sequence number wraps 4095 -> 0
        exp_seq = 12'd2;
        while (exp_seq != 12'hFFF) begin
            send_short(32'(exp_seq));
            exp_seq = exp_seq + 12'd1;
        end
        #1;
        chk("t5_seq_4095", 32'(seq_num), 32'h0000_0FFF);
        s_tuser = 3'b010; s_tvalid = 1'b1; s_tdata = 32'h0badf00d; s_tlast = 1'b1;
        step();
        #1;
        chk("t5_hdr_4095", m_tdata, 32'h0000_FF0F);
        step();
        step();
        s_tvalid = 1'b0;
        step();
        #1;
        chk("t5_seq_wrap", 32'(seq_num), 32'h0);
        s_tvalid = 1'b1;
        step();
        #1;
        chk("t5_hdr_wrap", m_tdata, 32'h0000_0000);
        step();
        step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        step();
        #1;
        chk("t5_seq_after", 32'(seq_num), 32'd1);

        // Replay of 5 preloaded words; replay wins over a pending TLP
        for (int k = 0; k < 5; k++) begin
            pre_we = 1'b1; pre_addr = 5'(k); pre_data = rdat[k];
            step();
        end
        pre_we = 1'b0;
        pulses_snap = pulses;
        retry = 1'b1; retry_index = 8'hE4;
        s_tuser = 3'b010; s_tvalid = 1'b1; s_tdata = 32'h12345678; s_tlast = 1'b1;
        step();
        #1;
        chkb("t6_rd_tvalid", m_tvalid, 1'b0);
        chk("t6_rd_addr", 32'(bram_addr), 32'd0);
        chkb("t6_rd_wr", bram_wr, 1'b0);
        chkb("t6_rd_tready", s_tready, 1'b0);
        retry = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        step();
        #1;
        chk("t6_w0_data", m_tdata, rdat[0]);
        chk("t6_w0_keep", 32'(m_tkeep), 32'h3);
        chkb("t6_w0_last", m_tlast, 1'b0);
        chk("t6_w0_addr", 32'(bram_addr), 32'd1);
        step();
        #1;
        chk("t6_w1_data", m_tdata, rdat[1]);
        chk("t6_w1_keep", 32'(m_tkeep), 32'hF);
        step();
        m_tready = 1'b0;
        #1;
        chk("t6_w2_stall_addr", 32'(bram_addr), 32'd2);
        chk("t6_w2_data", m_tdata, rdat[2]);
        step();
        #1;
        chk("t6_w2_hold", m_tdata, rdat[2]);
        chkb("t6_w2_hold_valid", m_tvalid, 1'b1);
        m_tready = 1'b1;
        step();
        #1;
        chk("t6_w3_data", m_tdata, rdat[3]);
        chkb("t6_w3_last", m_tlast, 1'b0);
        step();
        #1;
        chk("t6_w4_data", m_tdata, rdat[4]);
        chkb("t6_w4_last", m_tlast, 1'b1);
        chkb("t6_w4_wr", bram_wr, 1'b0);
        step();
        #1;
        chkb("t6_done_tvalid", m_tvalid, 1'b0);
        chk("t6_seq_kept", 32'(seq_num), 32'd1);
        chk("t6_no_pulse", 32'(pulses), 32'(pulses_snap));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
